fft_reorder_buf: RTL and testbench

//  Output reorder buffer for the radix-2 pipelined FFT. Sits after the last FFT stage and

---
 rtl/fft_reorder_buf.sv | 94 +++++++++
 tb/tb_fft_reorder_buf.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_buf.sv
// Output reorder buffer for the radix-2 pipelined FFT.
// Bit-reversed frames in, natural-order frames out, ping-pong banks.
module fft_reorder_buf #(
  parameter int width = 16,
  parameter int N     = 6
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    en_in,
  input  logic [N-1:0]            cnt_in,
  input  logic signed [width-1:0] xin_re,
  input  logic signed [width-1:0] xin_im,
  output logic                    en_out,
  output logic [N-1:0]            cnt_out,
  output logic signed [width-1:0] yout_re,
  output logic signed [width-1:0] yout_im,
  output logic                    ovf
);

  localparam int depth = 1 << N;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [2*width-1:0] mem [2*depth];

  logic         wr_bank;
  logic         rd_bank;
  logic         rd_active;
  logic [N-1:0] rd_addr;
  logic [N-1:0] wr_addr;
  logic         frame_done;
  logic         rd_last;
  logic         swap;

  // Bit-reverse the incoming index to get its natural-order slot.
  always_comb begin
    wr_addr = '0;
    for (int j = 0; j < N; j++) begin
      wr_addr[j] = cnt_in[N-1-j];
    end
  end

  assign frame_done = en_in && (cnt_in == '1);
  assign rd_last    = rd_active && (rd_addr == '1);
  // A finished frame is handed over only if the reader is idle or just finishing.
  assign swap       = frame_done && (!rd_active || rd_last);

  // Sample store; contents need no reset since reads follow writes.
  always_ff @(posedge clk) begin
    if (en_in) begin
      mem[{wr_bank, wr_addr}] <= {xin_re, xin_im};
    end
  end

  // Bank ownership, read pointer and overrun pulse.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      rd_active <= 1'b0;
      rd_addr   <= '0;
      ovf       <= 1'b0;
    end else begin
      ovf <= frame_done && !swap;
      if (swap) begin
        rd_bank   <= wr_bank;
        wr_bank   <= ~wr_bank;
        rd_active <= 1'b1;
        rd_addr   <= '0;
      end else if (rd_active) begin
        rd_addr <= rd_addr + 1'b1;
        if (rd_last) begin
          rd_active <= 1'b0;
        end
      end
    end
  end

  // Registered read port; data and index hold when the reader is idle.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      en_out  <= 1'b0;
      cnt_out <= '0;
      yout_re <= '0;
      yout_im <= '0;
    end else begin
      en_out <= rd_active;
      if (rd_active) begin
        {yout_re, yout_im} <= mem[{rd_bank, rd_addr}];
        cnt_out            <= rd_addr;
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder_buf.sv
// Directed bench for fft_reorder_buf.
// N=3 instance for framing tests, N=6 instance for extremes.
module tb_fft_reorder_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset;

  logic               en_in;
  logic [2:0]         cnt_in;
  logic signed [15:0] xin_re;
  logic signed [15:0] xin_im;
  logic               en_out;
  logic [2:0]         cnt_out;
  logic signed [15:0] yout_re;
  logic signed [15:0] yout_im;
  logic               ovf;

  logic               en6;
  logic [5:0]         cnt6;
  logic signed [15:0] re6;
  logic signed [15:0] im6;
  logic               en_out6;
  logic [5:0]         cnt_out6;
  logic signed [15:0] yre6;
  logic signed [15:0] yim6;
  logic               ovf6;

  fft_reorder_buf #(.width(16), .N(3)) dut (
    .clk    (clk),
    .areset (areset),
    .en_in  (en_in),
    .cnt_in (cnt_in),
    .xin_re (xin_re),
    .xin_im (xin_im),
    .en_out (en_out),
    .cnt_out(cnt_out),
    .yout_re(yout_re),
    .yout_im(yout_im),
    .ovf    (ovf)
  );

  fft_reorder_buf #(.width(16), .N(6)) dut6 (
    .clk    (clk),
    .areset (areset),
    .en_in  (en6),
    .cnt_in (cnt6),
    .xin_re (re6),
    .xin_im (im6),
    .en_out (en_out6),
    .cnt_out(cnt_out6),
    .yout_re(yre6),
    .yout_im(yim6),
    .ovf    (ovf6)
  );

  typedef struct {
    int cnt;
    int re;
    int im;
    int cyc;
  } smp_t;

  smp_t got_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   ovf_n = 0;
  int   ovf_cyc = -1;
  int   last_cyc = 0;
  int   n6 = 0;
  int   c32_re = 0;
  int   c32_im = 0;
  int   c1_re = 0;
  int   ovf6_n = 0;
  int   rev3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always @(posedge clk) cyc++;

  // Collect every output sample and overrun pulse away from the clock edge.
  always @(negedge clk) begin
    smp_t s;
    if (en_out) begin
      s.cnt = int'(cnt_out);
      s.re  = int'(yout_re);
      s.im  = int'(yout_im);
      s.cyc = cyc;
      got_q.push_back(s);
    end
    if (ovf) begin
      ovf_n++;
      ovf_cyc = cyc;
    end
    if (en_out6) begin
      n6++;
      if (cnt_out6 == 6'd32) begin
        c32_re = int'(yre6);
        c32_im = int'(yim6);
      end
      if (cnt_out6 == 6'd1) c1_re = int'(yre6);
    end
    if (ovf6) ovf6_n++;
  end

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int k, input int re, input int im);
    @(negedge clk);
    en_in    = 1'b1;
    cnt_in   = k[2:0];
    xin_re   = re[15:0];
    xin_im   = im[15:0];
    last_cyc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    en_in = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < 8; k++) send(k, base + k, -(base + k));
  endtask

  task automatic wait_n(input string tag, input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(tag, got_q.size() >= n, 1);
  endtask

  task automatic check_frame(input string tag, input int idx, input int base);
    for (int i = 0; i < 8; i++) begin
      if (idx + i < got_q.size()) begin
        chk($sformatf("%s cnt%0d", tag, i), got_q[idx+i].cnt, i);
        chk($sformatf("%s re%0d", tag, i), got_q[idx+i].re, base + rev3[i]);
        chk($sformatf("%s im%0d", tag, i), got_q[idx+i].im, -(base + rev3[i]));
      end else begin
        chk($sformatf("%s missing%0d", tag, i), 0, 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int b_cyc;
    areset = 1'b0;
    en_in  = 1'b0;
    cnt_in = '0;
    xin_re = '0;
    xin_im = '0;
    en6    = 1'b0;
    cnt6   = '0;
    re6    = '0;
    im6    = '0;
    #1;
    chk("rst en_out", en_out, 0);
    chk("rst cnt_out", cnt_out, 0);
    chk("rst yout_re", yout_re, 0);
    chk("rst yout_im", yout_im, 0);
    chk("rst ovf", ovf, 0);
    repeat (3) @(negedge clk);
    areset = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: single frame.
    got_q.delete();
    ovf_n = 0;
    send_frame(0);
    idle();
    wait_n("t1 wait", 8);
    check_frame("t1", 0, 0);
    if (got_q.size() > 0) chk("t1 latency", got_q[0].cyc - last_cyc, 2);
    if (got_q.size() > 7) chk("t1 span", got_q[7].cyc - got_q[0].cyc, 7);
    repeat (5) @(negedge clk);
    chk("t1 count", got_q.size(), 8);

    // Test 2: three frames back to back.
    got_q.delete();
    for (int f = 0; f < 3; f++) send_frame(16 * f);
    idle();
    wait_n("t2 wait", 24);
    for (int f = 0; f < 3; f++) check_frame($sformatf("t2 f%0d", f), 8 * f, 16 * f);
    if (got_q.size() > 23) chk("t2 gapless", got_q[23].cyc - got_q[0].cyc, 23);
    repeat (5) @(negedge clk);
    chk("t2 ovf", ovf_n, 0);
    chk("t2 count", got_q.size(), 24);

    // Test 3: overrun drops frame B, then frame C passes.
    got_q.delete();
    ovf_n = 0;
    send_frame(64);
    for (int k = 4; k < 8; k++) send(k, 128 + k, -(128 + k));
    b_cyc = last_cyc;
    idle();
    wait_n("t3 waitA", 8);
    chk("t3 ovf pulses", ovf_n, 1);
    chk("t3 ovf cycle", ovf_cyc - b_cyc, 1);
    check_frame("t3 A", 0, 64);
    repeat (3) @(negedge clk);
    send_frame(192);
    idle();
    wait_n("t3 waitC", 16);
    check_frame("t3 C", 8, 192);
    repeat (5) @(negedge clk);
    chk("t3 count", got_q.size(), 16);
    chk("t3 ovf final", ovf_n, 1);

    // Test 4: gapped input.
    got_q.delete();
    for (int k = 0; k < 8; k++) begin
      send(k, k, -k);
      idle();
    end
    wait_n("t4 wait", 8);
    check_frame("t4", 0, 0);
    if (got_q.size() > 0) chk("t4 latency", got_q[0].cyc - last_cyc, 2);

    // Test 5: reset during readout.
    repeat (5) @(negedge clk);
    got_q.delete();
    send_frame(32);
    idle();
    t = 0;
    while (!(en_out && cnt_out == 3'd3) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t5 reached cnt3", en_out && cnt_out == 3'd3, 1);
    areset = 1'b0;
    #1;
    chk("t5 en_out", en_out, 0);
    chk("t5 cnt_out", cnt_out, 0);
    chk("t5 yout_re", yout_re, 0);
    chk("t5 yout_im", yout_im, 0);
    @(negedge clk);
    areset = 1'b1;
    got_q.delete();
    repeat (12) @(negedge clk);
    chk("t5 quiet", got_q.size(), 0);
    send_frame(48);
    idle();
    wait_n("t5 wait", 8);
    check_frame("t5", 0, 48);

    // Test 6: N=6 extremes.
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      en6  = 1'b1;
      cnt6 = k[5:0];
      if (k == 1) begin
        re6 = -16'sd32768;
        im6 = 16'sd32767;
      end else begin
        re6 = k[15:0];
        im6 = -k[15:0];
      end
    end
    @(negedge clk);
    en6 = 1'b0;
    t = 0;
    while (n6 < 64 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t6 count", n6, 64);
    chk("t6 re32", c32_re, -32768);
    chk("t6 im32", c32_im, 32767);
    chk("t6 re1", c1_re, 32);
    chk("t6 ovf", ovf6_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
